ctrl_pipeline: RTL and testbench
================================

# ctrl_pipeline

Pipelined control-path consumer for the five-stage RISC-V core. Takes the ID-stage control bundle from the decode controller and carries it through the ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards and returns the `NoOp` request that squashes the decode controller's outputs. Also generates the PC/IF-ID stall, the IF/ID flush for taken branches, and the EX-stage forwarding selects.

## Interface
Parameters:
- ADDR_W, 5, register-address width

Ports:
- clk_i  in  1  core clock; all registers update on rising edge
- rst_i  in  1  asynchronous, active-low reset
- ALUOp_i  in  2  ID-stage ALU op class from decode controller
- ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, Branch_i  in  1 each  ID-stage control bits
- RS1addr_i, RS2addr_i, RDaddr_i  in  ADDR_W each  ID-stage register addresses from IF/ID instruction
- Equal_i  in  1  ID-stage branch comparator result (rs1 == rs2)
- NoOp_o  out  1  to decode controller; forces its control outputs to zero
- Stall_o  out  1  hold IF/ID register
- PCWrite_o  out  1  PC update enable
- Flush_o  out  1  clear IF/ID register (taken branch)
- EX_ALUOp_o  out  2  ID/EX stage ALU op class
- EX_ALUSrc_o  out  1  ID/EX stage ALU source select
- EX_RDaddr_o  out  ADDR_W  ID/EX stage destination register
- ForwardA_o, ForwardB_o  out  2 each  EX operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB result
- MEM_MemRead_o, MEM_MemWrite_o  out  1 each  EX/MEM stage memory strobes
- MEM_RegWrite_o  out  1  EX/MEM stage register write-back enable
- MEM_RDaddr_o  out  ADDR_W  EX/MEM stage destination register
- WB_RegWrite_o, WB_MemtoReg_o  out  1 each  MEM/WB stage write-back controls
- WB_RDaddr_o  out  ADDR_W  MEM/WB stage destination register

## Operation
- Pipeline stage registers:
  - ID/EX holds ALUOp, ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite, RS1, RS2, RD.
  - EX/MEM holds RegWrite, MemtoReg, MemRead, MemWrite, RD.
  - MEM/WB holds RegWrite, MemtoReg, RD.
  - Branch is consumed in ID and is not pipelined.
- All stages advance every cycle. There is no global enable.
- Load-use hazard, combinational:
  - hazard = EX_MemRead && EX_RD != 0 && (EX_RD == RS1addr_i || EX_RD == RS2addr_i).
- On hazard:
  - NoOp_o = 1, Stall_o = 1, PCWrite_o = 0.
  - ID/EX loads an all-zero control bundle (bubble) independent of the *_i control inputs. Addresses are also zeroed.
  - EX/MEM and MEM/WB advance normally.
- With no hazard:
  - NoOp_o = 0, Stall_o = 0, PCWrite_o = 1.
  - ID/EX captures the *_i inputs.
- Branch flush: Flush_o = Branch_i && Equal_i && !hazard. A stalled branch re-evaluates on the following cycle.
- Forwarding for A (B is identical, using EX_RS2):
  - 10 if MEM_RegWrite && MEM_RD != 0 && MEM_RD == EX_RS1.
  - Otherwise 01 if WB_RegWrite && WB_RD != 0 && WB_RD == EX_RS1.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB.
- Register x0 never triggers a hazard or a forward.
- Only the address compares are combinational. Every stage output is driven directly from a register.

## Timing
- Reset (rst_i low): every pipeline register clears to 0, asynchronously. As a result:
  - NoOp_o = 0, Stall_o = 0, Flush_o = 0, PCWrite_o = 1.
  - ForwardA_o = ForwardB_o = 00.
  - All EX_/MEM_/WB_ outputs are 0.
- Reset asserted mid-operation discards all in-flight control immediately. There is no partial drain.
- Latency: a control bundle accepted at edge N appears on:
  - EX_ outputs after edge N;
  - MEM_ outputs after edge N+1;
  - WB_ outputs after edge N+2.
- Load-use stall lasts exactly one cycle per load. After the bubble, EX_MemRead = 0, so the hazard drops and the dependent instruction then gets ForwardA/B = 01 from MEM/WB.
- Simultaneous events:
  - Hazard and taken branch in the same cycle: the stall wins and Flush_o = 0.
  - EX/MEM and MEM/WB both match the same source: 10 is selected.
- NoOp_o depends only on registered EX state and the IF/ID addresses, never on the *_i control bits. There is no combinational loop with the decode controller.

## Test plan
- Reset: drive rst_i low mid-stream with a non-zero pipeline -> all stage outputs 0 immediately; PCWrite_o = 1; ForwardA/B = 00.
- Plain flow: R-type with RegWrite_i = 1, RD = 5, ALUOp = 10 at edge 0 -> EX_RDaddr_o = 5 after edge 0; MEM_RDaddr_o = 5 after edge 1; WB_RegWrite_o = 1 and WB_RDaddr_o = 5 after edge 2.
- Load-use: lw x7, followed by an instruction with RS1 = 7 -> in the following cycle NoOp_o = 1, Stall_o = 1, PCWrite_o = 0. Next edge, all EX_ outputs are 0. One cycle later the stall clears and ForwardA_o = 01.
- x0 immunity: lw x0, followed by RS1 = 0 -> no stall. RegWrite to x0 followed by a reader of x0 -> ForwardA/B = 00.
- Forward priority: back-to-back writes to x3, then a reader of RS1 = RS2 = 3 -> ForwardA_o = ForwardB_o = 10. With one unrelated instruction in between -> 01.
- Branch:
  - Branch_i = 1, Equal_i = 1 with no hazard -> Flush_o = 1 for one cycle.
  - Same with EX lw writing the branch's RS1 -> Flush_o = 0 and Stall_o = 1. Next cycle Flush_o = 1.

Source files
------------

// File: rtl/ctrl_pipeline.sv
// Control-path pipeline for the five-stage core: ID/EX, EX/MEM and MEM/WB control registers,
// load-use hazard detection with bubble insertion, taken-branch flush and EX-stage forwarding selects.
module ctrl_pipeline #(
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              Branch_i,
  input  logic [ADDR_W-1:0] RS1addr_i,
  input  logic [ADDR_W-1:0] RS2addr_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic              Equal_i,
  output logic              NoOp_o,
  output logic              Stall_o,
  output logic              PCWrite_o,
  output logic              Flush_o,
  output logic [1:0]        EX_ALUOp_o,
  output logic              EX_ALUSrc_o,
  output logic [ADDR_W-1:0] EX_RDaddr_o,
  output logic [1:0]        ForwardA_o,
  output logic [1:0]        ForwardB_o,
  output logic              MEM_MemRead_o,
  output logic              MEM_MemWrite_o,
  output logic              MEM_RegWrite_o,
  output logic [ADDR_W-1:0] MEM_RDaddr_o,
  output logic              WB_RegWrite_o,
  output logic              WB_MemtoReg_o,
  output logic [ADDR_W-1:0] WB_RDaddr_o
);

  typedef struct packed {
    logic [1:0]        alu_op;
    logic              alu_src;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
  } idex_t;

  idex_t             r_idex;
  idex_t             w_idex_nxt;
  logic              r_mem_reg_write;
  logic              r_mem_mem_to_reg;
  logic              r_mem_mem_read;
  logic              r_mem_mem_write;
  logic [ADDR_W-1:0] r_mem_rd;
  logic              r_wb_reg_write;
  logic              r_wb_mem_to_reg;
  logic [ADDR_W-1:0] r_wb_rd;

  logic              w_hazard;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  // Uses only registered EX state and IF/ID addresses, so no loop through the decode controller.
  assign w_hazard = r_idex.mem_read && (r_idex.rd != '0) &&
                    ((r_idex.rd == RS1addr_i) || (r_idex.rd == RS2addr_i));

  always_comb begin
    w_idex_nxt = '0;
    if (!w_hazard) begin
      w_idex_nxt.alu_op     = ALUOp_i;
      w_idex_nxt.alu_src    = ALUSrc_i;
      w_idex_nxt.reg_write  = RegWrite_i;
      w_idex_nxt.mem_to_reg = MemtoReg_i;
      w_idex_nxt.mem_read   = MemRead_i;
      w_idex_nxt.mem_write  = MemWrite_i;
      w_idex_nxt.rs1        = RS1addr_i;
      w_idex_nxt.rs2        = RS2addr_i;
      w_idex_nxt.rd         = RDaddr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_idex           <= '0;
      r_mem_reg_write  <= 1'b0;
      r_mem_mem_to_reg <= 1'b0;
      r_mem_mem_read   <= 1'b0;
      r_mem_mem_write  <= 1'b0;
      r_mem_rd         <= '0;
      r_wb_reg_write   <= 1'b0;
      r_wb_mem_to_reg  <= 1'b0;
      r_wb_rd          <= '0;
    end else begin
      r_idex           <= w_idex_nxt;
      r_mem_reg_write  <= r_idex.reg_write;
      r_mem_mem_to_reg <= r_idex.mem_to_reg;
      r_mem_mem_read   <= r_idex.mem_read;
      r_mem_mem_write  <= r_idex.mem_write;
      r_mem_rd         <= r_idex.rd;
      r_wb_reg_write   <= r_mem_reg_write;
      r_wb_mem_to_reg  <= r_mem_mem_to_reg;
      r_wb_rd          <= r_mem_rd;
    end
  end

  // EX/MEM is checked last so it overrides a MEM/WB match on the same source.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (r_wb_reg_write && (r_wb_rd != '0) && (r_wb_rd == r_idex.rs1)) w_fwd_a = 2'b01;
    if (r_wb_reg_write && (r_wb_rd != '0) && (r_wb_rd == r_idex.rs2)) w_fwd_b = 2'b01;
    if (r_mem_reg_write && (r_mem_rd != '0) && (r_mem_rd == r_idex.rs1)) w_fwd_a = 2'b10;
    if (r_mem_reg_write && (r_mem_rd != '0) && (r_mem_rd == r_idex.rs2)) w_fwd_b = 2'b10;
  end

  assign NoOp_o         = w_hazard;
  assign Stall_o        = w_hazard;
  assign PCWrite_o      = !w_hazard;
  assign Flush_o        = Branch_i && Equal_i && !w_hazard;
  assign ForwardA_o     = w_fwd_a;
  assign ForwardB_o     = w_fwd_b;
  assign EX_ALUOp_o     = r_idex.alu_op;
  assign EX_ALUSrc_o    = r_idex.alu_src;
  assign EX_RDaddr_o    = r_idex.rd;
  assign MEM_MemRead_o  = r_mem_mem_read;
  assign MEM_MemWrite_o = r_mem_mem_write;
  assign MEM_RegWrite_o = r_mem_reg_write;
  assign MEM_RDaddr_o   = r_mem_rd;
  assign WB_RegWrite_o  = r_wb_reg_write;
  assign WB_MemtoReg_o  = r_wb_mem_to_reg;
  assign WB_RDaddr_o    = r_wb_rd;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed scenarios plus randomized traffic against a history-based model.
module tb_ctrl_pipeline;
  localparam int AW = 5;

  typedef struct packed {
    logic [1:0]    aluop;
    logic          alusrc;
    logic          regwrite;
    logic          memtoreg;
    logic          memread;
    logic          memwrite;
    logic          branch;
    logic          equal;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ins_t cur = '0;

  logic          noop, stall, pcwrite, flush, ex_alusrc;
  logic [1:0]    ex_aluop, fwd_a, fwd_b;
  logic [AW-1:0] ex_rd, mem_rd, wb_rd;
  logic          mem_memread, mem_memwrite, mem_regwrite, wb_regwrite, wb_memtoreg;

  ins_t hist[$];  // [0] in EX, [1] in MEM, [2] in WB
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ctrl_pipeline #(.ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .ALUOp_i(cur.aluop), .ALUSrc_i(cur.alusrc), .RegWrite_i(cur.regwrite),
    .MemtoReg_i(cur.memtoreg), .MemRead_i(cur.memread), .MemWrite_i(cur.memwrite),
    .Branch_i(cur.branch), .RS1addr_i(cur.rs1), .RS2addr_i(cur.rs2), .RDaddr_i(cur.rd),
    .Equal_i(cur.equal),
    .NoOp_o(noop), .Stall_o(stall), .PCWrite_o(pcwrite), .Flush_o(flush),
    .EX_ALUOp_o(ex_aluop), .EX_ALUSrc_o(ex_alusrc), .EX_RDaddr_o(ex_rd),
    .ForwardA_o(fwd_a), .ForwardB_o(fwd_b),
    .MEM_MemRead_o(mem_memread), .MEM_MemWrite_o(mem_memwrite),
    .MEM_RegWrite_o(mem_regwrite), .MEM_RDaddr_o(mem_rd),
    .WB_RegWrite_o(wb_regwrite), .WB_MemtoReg_o(wb_memtoreg), .WB_RDaddr_o(wb_rd)
  );

  wire [7:0]  obs_ctl   = {noop, stall, pcwrite, flush, fwd_a, fwd_b};
  wire [22:0] obs_stage = {ex_aluop, ex_alusrc, ex_rd, mem_memread, mem_memwrite,
                           mem_regwrite, mem_rd, wb_regwrite, wb_memtoreg, wb_rd};

  function automatic void m_reset();
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back('0);
  endfunction

  function automatic logic m_hazard();
    return hist[0].memread && hist[0].rd != 0 && (hist[0].rd == cur.rs1 || hist[0].rd == cur.rs2);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] src);
    if (hist[1].regwrite && hist[1].rd != 0 && hist[1].rd == src) return 2'b10;
    if (hist[2].regwrite && hist[2].rd != 0 && hist[2].rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [7:0] exp_ctl();
    logic hz;
    hz = m_hazard();
    return {hz, hz, !hz, cur.branch && cur.equal && !hz, m_fwd(hist[0].rs1), m_fwd(hist[0].rs2)};
  endfunction

  function automatic logic [22:0] exp_stage();
    return {hist[0].aluop, hist[0].alusrc, hist[0].rd, hist[1].memread, hist[1].memwrite,
            hist[1].regwrite, hist[1].rd, hist[2].regwrite, hist[2].memtoreg, hist[2].rd};
  endfunction

  // Advances one clock; the bundle accepted into EX is a bubble when the model sees a load-use hazard.
  task automatic tick();
    ins_t acc;
    acc = m_hazard() ? ins_t'('0) : cur;
    @(posedge clk);
    hist.push_front(acc);
    void'(hist.pop_back());
    #1;
  endtask

  task automatic settle();
    cur = '0;
    for (int i = 0; i < 3; i++) tick();
  endtask

  function automatic ins_t mk(input logic rw, input logic mr, input logic [AW-1:0] rs1,
                              input logic [AW-1:0] rs2, input logic [AW-1:0] rd);
    ins_t b;
    b = '0;
    b.regwrite = rw; b.memread = mr; b.memtoreg = mr; b.alusrc = mr;
    b.aluop = mr ? 2'b00 : 2'b10;
    b.rs1 = rs1; b.rs2 = rs2; b.rd = rd;
    return b;
  endfunction

  task automatic test_reset();
    cur = '0;
    m_reset();
    #2;
    checks++; if (obs_stage !== 23'd0) begin errors++; $display("FAIL reset_stage: got %h want 0", obs_stage); end
    checks++; if (obs_ctl !== 8'b0010_0000) begin errors++; $display("FAIL reset_ctl: got %b want 00100000", obs_ctl); end
    #5 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_plain_flow();
    settle();
    cur = mk(1'b1, 1'b0, 5'd1, 5'd2, 5'd5);
    tick();
    cur = '0;
    #4;
    checks++; if (ex_rd !== 5'd5 || ex_aluop !== 2'b10) begin errors++; $display("FAIL flow_ex: rd=%0d op=%b want rd=5 op=10", ex_rd, ex_aluop); end
    tick(); #4;
    checks++; if (mem_rd !== 5'd5 || mem_regwrite !== 1'b1) begin errors++; $display("FAIL flow_mem: rd=%0d rw=%b want rd=5 rw=1", mem_rd, mem_regwrite); end
    tick(); #4;
    checks++; if (wb_rd !== 5'd5 || wb_regwrite !== 1'b1) begin errors++; $display("FAIL flow_wb: rd=%0d rw=%b want rd=5 rw=1", wb_rd, wb_regwrite); end
    tick();
  endtask

  task automatic test_load_use();
    settle();
    cur = mk(1'b1, 1'b1, 5'd2, 5'd0, 5'd7);
    tick();
    cur = mk(1'b1, 1'b0, 5'd7, 5'd8, 5'd9);
    #4;
    checks++; if ({noop, stall, pcwrite} !== 3'b110) begin errors++; $display("FAIL lu_stall: noop/stall/pcw=%b want 110", {noop, stall, pcwrite}); end
    tick(); #4;
    checks++; if ({ex_aluop, ex_alusrc, ex_rd} !== 8'd0) begin errors++; $display("FAIL lu_bubble: ex=%h want 0", {ex_aluop, ex_alusrc, ex_rd}); end
    checks++; if ({noop, stall, pcwrite} !== 3'b001) begin errors++; $display("FAIL lu_release: noop/stall/pcw=%b want 001", {noop, stall, pcwrite}); end
    tick(); #4;
    checks++; if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin errors++; $display("FAIL lu_fwd: A=%b B=%b want A=01 B=00", fwd_a, fwd_b); end
    tick();
  endtask

  task automatic test_x0();
    settle();
    cur = mk(1'b1, 1'b1, 5'd1, 5'd0, 5'd0);
    tick();
    cur = mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    #4;
    checks++; if (stall !== 1'b0 || noop !== 1'b0) begin errors++; $display("FAIL x0_stall: stall=%b noop=%b want 0 0", stall, noop); end
    tick();
    cur = mk(1'b1, 1'b0, 5'd1, 5'd2, 5'd0);
    tick();
    cur = mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd10);
    tick(); #4;
    checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL x0_fwd: A=%b B=%b want 00 00", fwd_a, fwd_b); end
    tick();
  endtask

  task automatic test_fwd_priority();
    settle();
    cur = mk(1'b1, 1'b0, 5'd1, 5'd2, 5'd3); tick();
    cur = mk(1'b1, 1'b0, 5'd4, 5'd5, 5'd3); tick();
    cur = mk(1'b1, 1'b0, 5'd3, 5'd3, 5'd6); tick(); #4;
    checks++; if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin errors++; $display("FAIL fwd_prio: A=%b B=%b want 10 10", fwd_a, fwd_b); end
    settle();
    cur = mk(1'b1, 1'b0, 5'd1, 5'd2, 5'd3); tick();
    cur = mk(1'b1, 1'b0, 5'd1, 5'd2, 5'd4); tick();
    cur = mk(1'b1, 1'b0, 5'd3, 5'd3, 5'd6); tick(); #4;
    checks++; if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin errors++; $display("FAIL fwd_wb: A=%b B=%b want 01 01", fwd_a, fwd_b); end
    tick();
  endtask

  task automatic test_branch();
    settle();
    cur = mk(1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
    cur.branch = 1'b1; cur.equal = 1'b1;
    #4;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL br_flush: flush=%b want 1", flush); end
    tick();
    cur = '0;
    #4;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_oneshot: flush=%b want 0", flush); end
    tick();
    cur = mk(1'b1, 1'b1, 5'd1, 5'd0, 5'd6);
    tick();
    cur = mk(1'b0, 1'b0, 5'd6, 5'd2, 5'd0);
    cur.branch = 1'b1; cur.equal = 1'b1;
    #4;
    checks++; if (flush !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL br_hazard: flush=%b stall=%b want 0 1", flush, stall); end
    tick(); #4;
    checks++; if (flush !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL br_retry: flush=%b stall=%b want 1 0", flush, stall); end
    tick();
  endtask

  task automatic test_reset_mid();
    cur = mk(1'b1, 1'b1, 5'd1, 5'd2, 5'd9); tick();
    cur = mk(1'b1, 1'b0, 5'd3, 5'd4, 5'd11); tick();
    cur = '0;
    #1;
    checks++; if (obs_stage !== exp_stage()) begin errors++; $display("FAIL pre_reset: got %h want %h", obs_stage, exp_stage()); end
    rst_n = 1'b0;
    #1;
    m_reset();
    checks++; if (obs_stage !== 23'd0) begin errors++; $display("FAIL midreset_stage: got %h want 0", obs_stage); end
    checks++; if (obs_ctl !== 8'b0010_0000) begin errors++; $display("FAIL midreset_ctl: got %b want 00100000", obs_ctl); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cur.aluop    = 2'($urandom_range(0, 3));
      cur.alusrc   = 1'($urandom);
      cur.regwrite = 1'($urandom);
      cur.memtoreg = 1'($urandom);
      cur.memread  = ($urandom_range(0, 2) == 0);
      cur.memwrite = 1'($urandom);
      cur.branch   = 1'($urandom);
      cur.equal    = 1'($urandom);
      cur.rs1      = AW'($urandom_range(0, 3));
      cur.rs2      = AW'($urandom_range(0, 3));
      cur.rd       = AW'($urandom_range(0, 3));
      #4;
      checks++; if (obs_ctl !== exp_ctl()) begin errors++; $display("FAIL rnd_ctl[%0d]: got %b want %b", n, obs_ctl, exp_ctl()); end
      checks++; if (obs_stage !== exp_stage()) begin errors++; $display("FAIL rnd_stage[%0d]: got %h want %h", n, obs_stage, exp_stage()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_plain_flow();
    test_load_use();
    test_x0();
    test_fwd_priority();
    test_branch();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
